// File: rtl/radarpim_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : radarpim_sram_arbiter
// Purpose  : Two-port round-robin arbiter with optional burst lock that shares
//            one single-port synchronous-read SRAM cell between the AXI SRAM
//            controller (port A) and the PIM compute engine (port B). Read
//            data returns one cycle after the grant, tagged to its issuer.
// Options  : RADARPIM_SRAM_ARB_HOLD_LIMIT_EN - when defined, a locked owner
//            is forced off the cell after MAX_HOLD consecutive locked grants
//            if the other port is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module radarpim_sram_arbiter #(
    parameter int BW_INDEX = 16,
    parameter int BW_DATA  = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    // Port A: AXI SRAM controller
    input  logic                   a_req,
    output logic                   a_ready,
    input  logic                   a_we,
    input  logic [BW_INDEX-1:0]    a_index,
    input  logic [BW_DATA/8-1:0]   a_wstrb,
    input  logic [BW_DATA-1:0]     a_wdata,
    input  logic                   a_lock,
    output logic                   a_rvalid,
    output logic [BW_DATA-1:0]     a_rdata,
    // Port B: PIM compute engine
    input  logic                   b_req,
    output logic                   b_ready,
    input  logic                   b_we,
    input  logic [BW_INDEX-1:0]    b_index,
    input  logic [BW_DATA/8-1:0]   b_wstrb,
    input  logic [BW_DATA-1:0]     b_wdata,
    input  logic                   b_lock,
    output logic                   b_rvalid,
    output logic [BW_DATA-1:0]     b_rdata,
    // Memory cell
    output logic [BW_INDEX-1:0]    cell_index,
    output logic                   cell_wenable,
    output logic [BW_DATA/8-1:0]   cell_wpermit,
    output logic [BW_DATA-1:0]     cell_wdata,
    output logic                   cell_renable,
    input  logic [BW_DATA-1:0]     cell_rdata
);

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    // Reject illegal configurations at elaboration time
    if ((BW_DATA % 8) != 0 || MAX_HOLD < 1) begin : g_param_check
        $error("radarpim_sram_arbiter: BW_DATA must be a multiple of 8 and MAX_HOLD >= 1");
    end

    logic r_last_grant;
    logic r_lock_active;
    logic r_lock_owner;
    logic r_rd_pend;
    logic r_rd_owner;

    logic w_grant_a;
    logic w_grant_b;
    logic w_accept;
    logic w_sel_we;
    logic w_sel_lock;
    logic w_owner_req;
    logic w_other_req;
    logic w_hold_hit;

    assign w_owner_req = (r_lock_owner == c_PORT_B) ? b_req : a_req;
    assign w_other_req = (r_lock_owner == c_PORT_B) ? a_req : b_req;

`ifdef RADARPIM_SRAM_ARB_HOLD_LIMIT_EN
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);

    logic [c_HOLD_W-1:0] r_hold_cnt;

    // The owner has used its whole burst allowance and someone else waits
    assign w_hold_hit = r_lock_active && (r_hold_cnt == c_HOLD_MAX) && w_other_req;
`else
    assign w_hold_hit = 1'b0;
`endif

    // Grant selection: lock owner first, then single requester, then round-robin
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end else if (r_lock_active && w_hold_hit) begin
            w_grant_a = (r_lock_owner == c_PORT_B);
            w_grant_b = (r_lock_owner == c_PORT_A);
        end else if (r_lock_active && w_owner_req) begin
            w_grant_a = (r_lock_owner == c_PORT_A);
            w_grant_b = (r_lock_owner == c_PORT_B);
        end else if (a_req && !b_req) begin
            w_grant_a = 1'b1;
        end else if (b_req && !a_req) begin
            w_grant_b = 1'b1;
        end else if (a_req && b_req) begin
            w_grant_a = (r_last_grant == c_PORT_B);
            w_grant_b = (r_last_grant == c_PORT_A);
        end
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign w_accept   = w_grant_a | w_grant_b;
    assign w_sel_we   = w_grant_b ? b_we   : a_we;
    assign w_sel_lock = w_grant_b ? b_lock : a_lock;

    // Cell mux: the granted port drives the cell, everything is zero when idle
    always_comb begin
        cell_index   = '0;
        cell_wpermit = '0;
        cell_wdata   = '0;
        cell_wenable = 1'b0;
        cell_renable = 1'b0;
        if (w_grant_a) begin
            cell_index   = a_index;
            cell_wpermit = a_wstrb;
            cell_wdata   = a_wdata;
            cell_wenable = a_we;
            cell_renable = ~a_we;
        end else if (w_grant_b) begin
            cell_index   = b_index;
            cell_wpermit = b_wstrb;
            cell_wdata   = b_wdata;
            cell_wenable = b_we;
            cell_renable = ~b_we;
        end
    end

    // Round-robin history and read-return tag; a read pends for exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_PORT_B;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= c_PORT_A;
        end else begin
            r_rd_pend <= w_accept & ~w_sel_we;
            if (w_accept) begin
                r_last_grant <= w_grant_b;
                if (!w_sel_we) begin
                    r_rd_owner <= w_grant_b;
                end
            end
        end
    end

    // Burst lock: set by a locked accept, dropped by an unlocked accept, an
    // absent owner or a hold-limit override
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= c_PORT_A;
        end else if (w_accept && w_sel_lock && !w_hold_hit) begin
            r_lock_active <= 1'b1;
            r_lock_owner  <= w_grant_b;
        end else begin
            r_lock_active <= 1'b0;
        end
    end

`ifdef RADARPIM_SRAM_ARB_HOLD_LIMIT_EN
    // Consecutive locked grants of the current owner, restarting at 1 on an owner change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_accept && w_sel_lock && !w_hold_hit) begin
            if (r_lock_active && (r_lock_owner == w_grant_b)) begin
                if (r_hold_cnt != c_HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end else begin
                r_hold_cnt <= c_HOLD_W'(1);
            end
        end else begin
            r_hold_cnt <= '0;
        end
    end
`endif

    assign a_rvalid = r_rd_pend & (r_rd_owner == c_PORT_A);
    assign b_rvalid = r_rd_pend & (r_rd_owner == c_PORT_B);
    assign a_rdata  = cell_rdata;
    assign b_rdata  = cell_rdata;

endmodule
`default_nettype wire

// File: tb/tb_radarpim_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_radarpim_sram_arbiter
// Purpose  : Directed self-checking bench for radarpim_sram_arbiter with a
//            behavioural byte-writable synchronous-read cell model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radarpim_sram_arbiter;

    localparam int BW_INDEX = 16;
    localparam int BW_DATA  = 32;
    localparam int MH       = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 a_req, a_ready, a_we, a_lock, a_rvalid;
    logic [BW_INDEX-1:0]  a_index;
    logic [3:0]           a_wstrb;
    logic [BW_DATA-1:0]   a_wdata, a_rdata;
    logic                 b_req, b_ready, b_we, b_lock, b_rvalid;
    logic [BW_INDEX-1:0]  b_index;
    logic [3:0]           b_wstrb;
    logic [BW_DATA-1:0]   b_wdata, b_rdata;
    logic [BW_INDEX-1:0]  cell_index;
    logic                 cell_wenable, cell_renable;
    logic [3:0]           cell_wpermit;
    logic [BW_DATA-1:0]   cell_wdata;
    logic [BW_DATA-1:0]   cell_rdata;

    logic [BW_DATA-1:0]   mem [0:255];

    int checks   = 0;
    int failures = 0;
    int na, nb;

    always #5 clk = ~clk;

    radarpim_sram_arbiter #(
        .BW_INDEX (BW_INDEX),
        .BW_DATA  (BW_DATA),
        .MAX_HOLD (MH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req        (a_req),
        .a_ready      (a_ready),
        .a_we         (a_we),
        .a_index      (a_index),
        .a_wstrb      (a_wstrb),
        .a_wdata      (a_wdata),
        .a_lock       (a_lock),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_ready      (b_ready),
        .b_we         (b_we),
        .b_index      (b_index),
        .b_wstrb      (b_wstrb),
        .b_wdata      (b_wdata),
        .b_lock       (b_lock),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .cell_index   (cell_index),
        .cell_wenable (cell_wenable),
        .cell_wpermit (cell_wpermit),
        .cell_wdata   (cell_wdata),
        .cell_renable (cell_renable),
        .cell_rdata   (cell_rdata)
    );

    // Cell model: byte-permitted write, one-cycle synchronous read
    always @(posedge clk) begin
        if (cell_renable) cell_rdata <= mem[cell_index[7:0]];
        if (cell_wenable) begin
            for (int i = 0; i < 4; i++)
                if (cell_wpermit[i]) mem[cell_index[7:0]][i*8 +: 8] <= cell_wdata[i*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [15:0] idx,
                         input logic [3:0] strb, input logic [31:0] d, input logic lk);
        a_req = req; a_we = we; a_index = idx; a_wstrb = strb; a_wdata = d; a_lock = lk;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [15:0] idx,
                         input logic [3:0] strb, input logic [31:0] d, input logic lk);
        b_req = req; b_we = we; b_index = idx; b_wstrb = strb; b_wdata = d; b_lock = lk;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        cell_rdata = '0;
        rst = 1'b1;
        set_a(1'b1, 1'b0, 16'h10, 4'h0, 32'h0, 1'b0);
        set_b(1'b1, 1'b0, 16'h20, 4'h0, 32'h0, 1'b0);
        #1;
        // Reset state
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("rst_cell_ren", cell_renable, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Contention: both read, round-robin starting with A
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_a_ready_%0d", k), a_ready, (k % 2 == 0));
            chk($sformatf("rr_b_ready_%0d", k), b_ready, (k % 2 == 1));
            chk($sformatf("rr_index_%0d", k), cell_index, (k % 2 == 0) ? 16'h10 : 16'h20);
            chk($sformatf("rr_ren_%0d", k), {cell_renable, cell_wenable}, 2'b10);
            step();
            chk($sformatf("rr_rvalid_%0d", k), {a_rvalid, b_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("rr_rdata_%0d", k), (k % 2 == 0) ? a_rdata : b_rdata,
                (k % 2 == 0) ? 32'hA000_0010 : 32'hA000_0020);
            #1;
        end

        // Idle: cell outputs zero
        set_a(1'b0, 1'b0, 16'h33, 4'hF, 32'h1234, 1'b0);
        set_b(1'b0, 1'b0, 16'h44, 4'hF, 32'h5678, 1'b0);
        #1;
        chk("idle_cell", {cell_index, cell_wenable, cell_renable, cell_wpermit, cell_wdata}, 0);
        step();

        // Full write by A, read back by B
        set_a(1'b1, 1'b1, 16'h5, 4'hF, 32'hDEADBEEF, 1'b0);
        #1;
        chk("wr_a_ready", a_ready, 1);
        chk("wr_cell", {cell_wenable, cell_renable, cell_wpermit, cell_wdata}, {2'b10, 4'hF, 32'hDEADBEEF});
        step();
        chk("wr_no_rvalid", {a_rvalid, b_rvalid}, 0);
        set_a(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        set_b(1'b1, 1'b0, 16'h5, 4'h0, 32'h0, 1'b0);
        #1;
        chk("rd5_b_ready", b_ready, 1);
        step();
        chk("rd5_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
        chk("rd5_b_rdata", b_rdata, 32'hDEADBEEF);
        // Partial write, byte 0 only
        set_b(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        set_a(1'b1, 1'b1, 16'h5, 4'h1, 32'h0000_0055, 1'b0);
        step();
        set_a(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        set_b(1'b1, 1'b0, 16'h5, 4'h0, 32'h0, 1'b0);
        step();
        chk("rd5_partial", {b_rvalid, b_rdata}, {1'b1, 32'hDEADBE55});

        // Burst lock by B
        set_b(1'b1, 1'b0, 16'h7, 4'h0, 32'h0, 1'b1);
        #1;
        chk("lock_first_b", b_ready, 1);
        step();
        set_a(1'b1, 1'b0, 16'h8, 4'h0, 32'h0, 1'b0);
        na = 0;
        nb = 0;
`ifdef RADARPIM_SRAM_ARB_HOLD_LIMIT_EN
        for (int c = 0; c < MH - 1; c++) begin
            #1;
            na += int'(a_ready);
            nb += int'(b_ready);
            step();
        end
        chk("hold_b_grants", nb, MH - 1);
        chk("hold_a_starved", na, 0);
        #1;
        chk("hold_override", {a_ready, b_ready}, 2'b10);
        step();
`else
        for (int c = 0; c < 39; c++) begin
            #1;
            na += int'(a_ready);
            nb += int'(b_ready);
            step();
        end
        chk("lock_b_grants", nb, 39);
        chk("lock_a_starved", na, 0);
        b_lock = 1'b0;
        #1;
        chk("unlock_beat_b", {a_ready, b_ready}, 2'b01);
        step();
        #1;
        chk("unlock_next_a", {a_ready, b_ready}, 2'b10);
        step();
`endif
        set_a(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        set_b(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        step();

        // Reset right after an A read accept
        set_a(1'b1, 1'b0, 16'h10, 4'h0, 32'h0, 1'b0);
        #1;
        chk("pre_rst_a_ready", a_ready, 1);
        step();
        chk("pre_rst_a_rvalid", a_rvalid, 1);
        b_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("mid_rst_ready", {a_ready, b_ready}, 0);
        chk("mid_rst_cell", {cell_index, cell_wenable, cell_renable, cell_wpermit, cell_wdata}, 0);
        step();
        chk("mid_rst_hold", {a_ready, b_ready, a_rvalid, b_rvalid}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_first_a", {a_ready, b_ready}, 2'b10);
        step();
        set_a(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        set_b(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        step();

        // B alone, back-to-back reads
        for (int k = 0; k < 8; k++) begin
            set_b(1'b1, 1'b0, 16'h20 + 16'(k), 4'h0, 32'h0, 1'b0);
            #1;
            chk($sformatf("bonly_ready_%0d", k), {a_ready, b_ready}, 2'b01);
            step();
            chk($sformatf("bonly_rvalid_%0d", k), {a_rvalid, b_rvalid}, 2'b01);
            chk($sformatf("bonly_rdata_%0d", k), b_rdata, 32'hA000_0020 + k);
        end
        set_b(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        step();
        chk("bonly_end", {a_rvalid, b_rvalid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
